// File: rtl/data_memory_ctrl.sv
// Word-addressed data memory with a ready/valid request port, single or double-word
// access (double = high word at addr, low word at addr+1) and an out-of-range error pulse.
module data_memory_ctrl #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DEPTH  = 2048
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic                  req_double,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [2*DATA_W-1:0]   req_wdata,
  output logic                  rd_valid,
  output logic [2*DATA_W-1:0]   rd_data,
  output logic                  err
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  typedef enum logic {
    IDLE,
    SECOND
  } state_e;

  state_e                 state_q, state_d;
  logic                   ready_q, ready_d;
  logic                   rd_valid_q, rd_valid_d;
  logic                   err_q, err_d;
  logic [2*DATA_W-1:0]    rd_data_q, rd_data_d;
  logic [IDX_W-1:0]       addr2_q, addr2_d;
  logic [DATA_W-1:0]      lo_q, lo_d;
  logic [DATA_W-1:0]      hi_q, hi_d;
  logic                   wr2_q, wr2_d;

  logic [DATA_W-1:0]      mem [DEPTH];
  logic                   mem_we;
  logic [IDX_W-1:0]       mem_waddr;
  logic [DATA_W-1:0]      mem_wdata;

  logic                   accept;
  logic [ADDR_W:0]        addr_ext;
  logic [ADDR_W:0]        addr_p1;
  logic                   in_range;
  logic [IDX_W-1:0]       addr_idx;
  logic [DATA_W-1:0]      word_a;
  logic [DATA_W-1:0]      word_b;

  assign accept    = req_valid && ready_q;
  assign addr_ext  = {1'b0, req_addr};
  // addr+1 is formed one bit wider so the top address cannot wrap to 0
  assign addr_p1   = addr_ext + (ADDR_W+1)'(1);
  assign in_range  = req_double ? (addr_p1 < DEPTH_L) : (addr_ext < DEPTH_L);
  assign addr_idx  = req_addr[IDX_W-1:0];
  assign word_a    = mem[addr_idx];
  assign word_b    = mem[addr2_q];

  // Next-state, memory write port and registered output values
  always_comb begin
    state_d    = state_q;
    addr2_d    = addr2_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    wr2_d      = wr2_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    err_d      = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = addr_idx;
    mem_wdata  = req_wdata[DATA_W-1:0];

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (!in_range) begin
            err_d = 1'b1;
          end else if (!req_double) begin
            if (req_write) begin
              mem_we = 1'b1;
            end else begin
              rd_data_d  = {{DATA_W{1'b0}}, word_a};
              rd_valid_d = 1'b1;
            end
          end else begin
            state_d = SECOND;
            addr2_d = addr_idx + IDX_W'(1);
            wr2_d   = req_write;
            if (req_write) begin
              mem_we    = 1'b1;
              mem_wdata = req_wdata[2*DATA_W-1:DATA_W];
              lo_d      = req_wdata[DATA_W-1:0];
            end else begin
              hi_d = word_a;
            end
          end
        end
      end
      SECOND: begin
        state_d = IDLE;
        if (wr2_q) begin
          mem_we    = 1'b1;
          mem_waddr = addr2_q;
          mem_wdata = lo_q;
        end else begin
          rd_data_d  = {hi_q, word_b};
          rd_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // reset aborts any pending second-word write
    if (rst) begin
      mem_we = 1'b0;
    end
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ready_q    <= 1'b1;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
      rd_data_q  <= '0;
      addr2_q    <= '0;
      lo_q       <= '0;
      hi_q       <= '0;
      wr2_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
      rd_data_q  <= rd_data_d;
      addr2_q    <= addr2_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
      wr2_q      <= wr2_d;
    end
  end

  // Storage array is intentionally not reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign req_ready = ready_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign err       = err_q;

endmodule
